// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared types and defaults for the period meter
package period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 32'd1000000;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer with registered rise/fall pulses
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Pulses appear three clk edges after the input edge and last one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow clock in clk cycles
module period_meter
    import period_meter_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             meas_clk,
    input  logic             start,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] div_value,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcap;
    logic [CNT_W-1:0] tcnt;
    logic             to_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    sync_edge_detect u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (meas_clk),
        .rise  (rise),
        .fall  (fall)
    );

    assign to_hit = (tcnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout wins over a coincident rise so the start-to-exit bound always holds.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_ARM;
            ST_ARM:     if (to_hit) state_nxt = ST_IDLE;
                        else if (rise) state_nxt = ST_MEASURE;
            ST_MEASURE: if (to_hit) state_nxt = ST_IDLE;
                        else if (rise) state_nxt = ST_DONE;
            ST_DONE:    if (ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        valid = 1'b0;
        case (state)
            ST_ARM, ST_MEASURE: busy  = 1'b1;
            ST_DONE:            valid = 1'b1;
            default:            ;
        endcase
    end

    // High time is captured privately so an abandoned run leaves the last result intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            hcap      <= '0;
            tcnt      <= '0;
            timeout   <= 1'b0;
            period    <= '0;
            high_time <= '0;
            div_value <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tcnt    <= '0;
                        timeout <= 1'b0;
                    end
                end
                ST_ARM: begin
                    tcnt <= sat_inc(tcnt);
                    if (to_hit) begin
                        timeout <= 1'b1;
                    end else if (rise) begin
                        cnt  <= ONE;
                        hcap <= '0;
                    end
                end
                ST_MEASURE: begin
                    tcnt <= sat_inc(tcnt);
                    if (to_hit) begin
                        timeout <= 1'b1;
                    end else if (rise) begin
                        period    <= cnt;
                        high_time <= hcap;
                        div_value <= (cnt < TWO) ? '0 : (cnt >> 1) - ONE;
                    end else begin
                        if (fall) hcap <= cnt;
                        cnt <= sat_inc(cnt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - randomized self-checking bench for period_meter
module tb_period_meter;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 100;

    logic             clk;
    logic             reset;
    logic             meas_clk;
    logic             start;
    logic             ready;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] div_value;
    logic             valid;
    logic             busy;
    logic             timeout;

    int n_checks = 0;
    int n_pass   = 0;

    bit meas_en = 0;
    int hi_cyc  = 5;
    int lo_cyc  = 5;
    int ph      = 0;

    longint last_p = 0;
    longint last_h = 0;
    longint last_d = 0;

    period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .meas_clk  (meas_clk),
        .start     (start),
        .period    (period),
        .high_time (high_time),
        .div_value (div_value),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Waveform under measurement: hi_cyc clk cycles high, lo_cyc low, starting high.
    always @(negedge clk) begin
        if (!meas_en) begin
            meas_clk = 0;
            ph = 0;
        end else begin
            meas_clk = (ph < hi_cyc);
            ph = (ph + 1 >= hi_cyc + lo_cyc) ? 0 : ph + 1;
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint model_div(input longint p);
        return (p < 2) ? 0 : (p / 2) - 1;
    endfunction

    task automatic set_wave(input int h, input int l);
        meas_en = 0;
        repeat (5) @(negedge clk);
        hi_cyc  = h;
        lo_cyc  = l;
        meas_en = 1;
    endtask

    task automatic wait_valid(output bit seen, input bit extra_starts);
        seen = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start = extra_starts ? 1'($urandom_range(0, 1)) : 1'b0;
            if (valid) begin
                seen = 1;
                break;
            end
        end
        check_eq("valid_seen", seen, 1);
    endtask

    task automatic run_meas(input int h, input int l, input bit extra_starts);
        bit seen;
        longint ep;
        ep = h + l;
        set_wave(h, l);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        check_eq("busy_after_start", busy, 1);
        wait_valid(seen, extra_starts);
        check_eq("period", period, ep);
        check_eq("high_time", high_time, h);
        check_eq("div_value", div_value, model_div(ep));
        check_eq("timeout_clear", timeout, 0);
        last_p = ep;
        last_h = h;
        last_d = model_div(ep);
        @(negedge clk);
        start = 0;
        check_eq("idle_after_hs_valid", valid, 0);
        check_eq("idle_after_hs_busy", busy, 0);
    endtask

    initial begin
        int n_high;
        bit seen;
        reset = 1;
        start = 0;
        ready = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check_eq("rst_period", period, 0);
        check_eq("rst_high_time", high_time, 0);
        check_eq("rst_div_value", div_value, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_timeout", timeout, 0);

        run_meas(5, 5, 0);
        run_meas(7, 6, 0);
        run_meas(1, 1, 0);
        run_meas(3, 4, 1);

        for (int i = 0; i < 8; i++) begin
            run_meas($urandom_range(1, 20), $urandom_range(1, 20), 1'($urandom_range(0, 1)));
        end

        // Stuck-low meas_clk: abandon after exactly TIMEOUT busy cycles.
        meas_en = 0;
        repeat (5) @(negedge clk);
        start = 1;
        n_high = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            start = 0;
            if (!busy) break;
            n_high++;
        end
        check_eq("timeout_busy_cycles", n_high, TIMEOUT);
        check_eq("timeout_flag", timeout, 1);
        check_eq("timeout_valid", valid, 0);
        check_eq("timeout_period_kept", period, last_p);
        check_eq("timeout_high_kept", high_time, last_h);
        check_eq("timeout_div_kept", div_value, last_d);

        // Consumer stall: results hold while ready is low, starts are ignored.
        ready = 0;
        set_wave(8, 5);
        start = 1;
        @(negedge clk);
        start = 0;
        check_eq("restart_clears_timeout", timeout, 0);
        wait_valid(seen, 0);
        for (int i = 0; i < 20; i++) begin
            check_eq("stall_valid", valid, 1);
            check_eq("stall_period", period, 13);
            check_eq("stall_high", high_time, 8);
            check_eq("stall_div", div_value, 5);
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 0;
        ready = 1;
        @(negedge clk);
        check_eq("stall_release_valid", valid, 0);
        check_eq("stall_release_busy", busy, 0);

        // Reset in the middle of a measurement.
        meas_en = 0;
        repeat (5) @(negedge clk);
        hi_cyc = 15;
        lo_cyc = 15;
        start  = 1;
        @(negedge clk);
        start   = 0;
        meas_en = 1;
        repeat (12) @(negedge clk);
        check_eq("mid_busy", busy, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check_eq("mid_rst_period", period, 0);
        check_eq("mid_rst_high", high_time, 0);
        check_eq("mid_rst_div", div_value, 0);
        check_eq("mid_rst_valid", valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_timeout", timeout, 0);
        run_meas(9, 4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of all measurement outputs and internal counters.
REQ-002 SHALL have parameter TIMEOUT, default 1000000: max clk cycles from accepted start to result; TIMEOUT < 2^CNT_W.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port meas_clk  input  1  slow clock under measurement, e.g. a divided clock; asynchronous to clk.
REQ-006 SHALL have port start  input  1  request one measurement; level sampled each cycle.
REQ-007 SHALL have port period  output  CNT_W  clk cycles between two consecutive meas_clk rising edges.
REQ-008 SHALL have port high_time  output  CNT_W  clk cycles meas_clk was high within that period.
REQ-009 SHALL have port div_value  output  CNT_W  equivalent divider setting: (period>>1)-1, or 0 if period<2.
REQ-010 SHALL have port valid  output  1  result outputs hold a fresh measurement.
REQ-011 SHALL have port ready  input  1  consumer accepts result when valid&ready.
REQ-012 SHALL have port busy  output  1  high in ARM and MEASURE states.
REQ-013 SHALL have port timeout  output  1  sticky flag: last measurement was abandoned.

Function
REQ-014 meas_clk SHALL pass a 2-flop synchronizer plus an edge register; rise/fall pulses are 1 clk wide, 3 cycles after the input edge.
REQ-015 FSM states SHALL be IDLE, ARM, MEASURE, DONE.
REQ-016 IDLE -> ARM when start=1; the same cycle clears timeout and the timeout counter.
REQ-017 ARM -> MEASURE on the first rise pulse; the period counter loads 1 on that cycle.
REQ-018 In MEASURE, the period counter SHALL increment by 1 each cycle; on a fall pulse it latches the current count into high_time.
REQ-019 MEASURE -> DONE on the next rise pulse; period latches the count, so period equals t_rise2 - t_rise1 in clk cycles.
REQ-020 div_value SHALL be registered together with period; odd periods truncate.
REQ-021 In DONE, valid=1 and outputs SHALL hold stable until valid&ready; then the FSM goes to IDLE and valid=0 on the next cycle.
REQ-022 start in ARM, MEASURE or DONE SHALL be ignored; start coincident with the handshake SHALL be ignored and must be re-asserted.
REQ-023 The timeout counter SHALL run in ARM and MEASURE; on reaching TIMEOUT-1, FSM -> IDLE, timeout=1, and period, high_time, div_value and valid are unchanged from the prior result.
REQ-024 If no fall pulse occurs in MEASURE, high_time SHALL be 0.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-026 reset SHALL force IDLE and set period=0, high_time=0, div_value=0, valid=0, busy=0, timeout=0, and clear all synchronizer and counter flops.
REQ-027 reset asserted mid-measurement SHALL abandon it with no valid pulse; reset dominates start and ready.

Structure
REQ-028 Package period_meter_pkg SHALL hold the FSM state enum and the default TIMEOUT constant.
REQ-029 Sub-module sync_edge_detect SHALL implement the synchronizer and the rise/fall pulses (REQ-014).
REQ-030 RTL SHALL be fully synchronous, single clock domain except for the meas_clk input; no latches.

Verification
REQ-031 meas_clk from a divider with div_value=4 on clk (period 10, 5 high), start pulse, ready=1 -> valid with period=10, high_time=5, div_value=4.
REQ-032 meas_clk with 7 cycles high and 6 low -> period=13, high_time=7, div_value=5.
REQ-033 meas_clk held 0, TIMEOUT=100 -> busy drops exactly 100 cycles after start, timeout=1, valid stays 0.
REQ-034 ready=0 for 20 cycles after valid -> outputs stable for all 20 cycles; extra start pulses ignored; IDLE the cycle after ready=1.
REQ-035 reset pulse during MEASURE -> next cycle all outputs 0 and IDLE; a new start then measures correctly.
REQ-036 start while busy -> no restart; result matches the first measurement.
